// File: rtl/mod_counter_disp.sv
// Up/down modulo counter with load/clamp, terminal count and a multiplexed
// active-low 7-segment hex display. Define COUNTER_PRESCALE_EN to add a count prescaler.
module mod_counter_disp #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 10,
  parameter int SCAN_DIV = 4
`ifdef COUNTER_PRESCALE_EN
  ,
  parameter int PRESCALE = 4
`endif
  ,
  localparam int NDIG = (WIDTH + 3) / 4
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             iEn,
  input  logic             iUp,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iLoadVal,
  output logic [WIDTH-1:0] oQ,
  output logic             oTC,
  output logic [6:0]       oSeg,
  output logic [NDIG-1:0]  oAn
);

  localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic          count_tick;
  logic          at_max;
  logic          at_zero;
  logic          load_ok;
  logic [SW-1:0] scan;
  logic [DW-1:0] dig;
  logic [NDIG*4-1:0] q_pad;
  logic [3:0]    nibble;

  assign at_max  = (oQ == Q_MAX);
  assign at_zero = (oQ == '0);
  assign load_ok = (32'(iLoadVal) < MODULUS);

`ifdef COUNTER_PRESCALE_EN
  localparam int PW = $clog2(PRESCALE);
  logic [PW-1:0] pre;

  assign count_tick = iEn & (pre == PW'(PRESCALE - 1));

  // A load restarts the prescale period so the loaded value gets a full period.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n)     pre <= '0;
    else if (iLoad) pre <= '0;
    else if (iEn)   pre <= count_tick ? '0 : pre + PW'(1);
  end
`else
  assign count_tick = iEn;
`endif

  assign oTC = count_tick & ~iLoad & ((iUp & at_max) | (~iUp & at_zero));

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      oQ <= '0;
    end else if (iLoad) begin
      oQ <= load_ok ? iLoadVal : Q_MAX;
    end else if (count_tick) begin
      if (iUp) oQ <= at_max  ? '0    : oQ + WIDTH'(1);
      else     oQ <= at_zero ? Q_MAX : oQ - WIDTH'(1);
    end
  end

  // Display scan runs free of the counter controls.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      scan <= '0;
      dig  <= '0;
    end else if (scan == SW'(SCAN_DIV - 1)) begin
      scan <= '0;
      dig  <= (dig == DW'(NDIG - 1)) ? '0 : dig + DW'(1);
    end else begin
      scan <= scan + SW'(1);
    end
  end

  always_comb begin
    oAn = '1;
    for (int i = 0; i < NDIG; i++) oAn[i] = (dig != DW'(i));
  end

  always_comb begin
    q_pad = '0;
    q_pad[WIDTH-1:0] = oQ;
    nibble = q_pad[4*int'(dig) +: 4];
  end

  always_comb begin
    case (nibble)
      4'h0:    oSeg = 7'b1000000;
      4'h1:    oSeg = 7'b1111001;
      4'h2:    oSeg = 7'b0100100;
      4'h3:    oSeg = 7'b0110000;
      4'h4:    oSeg = 7'b0011001;
      4'h5:    oSeg = 7'b0010010;
      4'h6:    oSeg = 7'b0000010;
      4'h7:    oSeg = 7'b1111000;
      4'h8:    oSeg = 7'b0000000;
      4'h9:    oSeg = 7'b0010000;
      4'hA:    oSeg = 7'b0001000;
      4'hB:    oSeg = 7'b0000011;
      4'hC:    oSeg = 7'b1000110;
      4'hD:    oSeg = 7'b0100001;
      4'hE:    oSeg = 7'b0000110;
      default: oSeg = 7'b0001110;
    endcase
  end

endmodule
